mc_control: RTL
===============

# mc_control

Multicycle control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the ALU's 3-bit operation code and operand selects, and consumes the ALU `zero` flag for branch resolution. It also handshakes with a variable-latency unified memory, so the same datapath can run with wait-stated memory.

## Interface
Parameters:
- `ADDR_W`, 32: width of the performance counters (compiled in only under `MC_CTRL_PERF_EN`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `opcode` in 6: instruction bits [31:26] from the instruction register.
- `funct` in 6: instruction bits [5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `mem_req` out 1: memory access requested.
- `mem_we` out 1: request is a write.
- `iord` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the instruction register.
- `pc_en` out 1: PC load enable = `pc_write` OR (`pc_write_cond` AND `zero`).
- `pc_src` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` out 1: ALU A operand; 0 = PC, 1 = register A.
- `alu_src_b` out 2: ALU B operand; 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_ctrl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `reg_dst` out 1: destination register; 1 = rd, 0 = rt.
- `mem_to_reg` out 1: writeback source; 1 = MDR, 0 = ALUOut.
- `reg_write` out 1: register file write enable.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode or funct.
- `state_o` out 4: current state, for debug.

## Operation
- States and transitions:
  - FETCH(0): to DECODE when `mem_ready` is high.
  - DECODE(1), dispatch on `opcode`:
    - R-type 000000 → EXEC.
    - lw 100011 or sw 101011 → MEMADR.
    - beq 000100 → BRANCH.
    - addi 001000 → ADDIEX.
    - j 000010 → JUMP.
    - Any other opcode, or an R-type with an unsupported funct → FETCH, with `illegal_op` pulsed in DECODE.
  - MEMADR(2): lw → MEMRD, sw → MEMWR.
  - MEMRD(3): to MEMWB when `mem_ready` is high.
  - MEMWB(4): to FETCH.
  - MEMWR(5): to FETCH when `mem_ready` is high.
  - EXEC(6): to ALUWB. ALUWB(7): to FETCH.
  - BRANCH(8): to FETCH.
  - ADDIEX(9): to ADDIWB. ADDIWB(10): to FETCH.
  - JUMP(11): to FETCH.
- Supported funct codes:
  - 100000 → alu_ctrl 010 (add).
  - 100010 → 110 (sub).
  - 100100 → 000 (and).
  - 100101 → 001 (or).
  - 101010 → 111 (slt).
- Per-state outputs (outputs not listed are 0):
  - FETCH: `mem_req`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_ctrl`=010, `pc_src`=00. `ir_write` and `pc_write` are asserted only when `mem_ready` is high.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_ctrl`=010 (branch target computed into ALUOut).
  - MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_ctrl`=010.
  - MEMRD: `mem_req`, `iord`=1.
  - MEMWR: `mem_req`, `mem_we`, `iord`=1.
  - MEMWB: `reg_write`, `mem_to_reg`=1, `reg_dst`=0.
  - EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl` from funct.
  - ALUWB: `reg_write`, `reg_dst`=1, `mem_to_reg`=0.
  - ADDIWB: `reg_write`, `reg_dst`=0, `mem_to_reg`=0.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl`=110, `pc_write_cond`, `pc_src`=01.
  - JUMP: `pc_write`, `pc_src`=10.
- `funct` is ignored for non-R-type instructions.

## Timing
- Outputs are combinational from the state register; `mem_ready` gates `ir_write` and `pc_write`. Only the state register is clocked.
- Reset:
  - State = FETCH.
  - While `rst` is high, all outputs are forced to 0, including `mem_req` and `state_o`=0.
  - `mem_req` first asserts in the cycle after `rst` deasserts.
- Asserting `rst` mid-instruction abandons the instruction. Any pending memory request is dropped immediately; memory must tolerate `mem_req` falling without `mem_ready`.
- Memory handshake: `mem_req` stays asserted, with `iord` and `mem_we` stable, until the first rising edge at which `mem_ready` is high. `mem_ready` in the same cycle as the request is legal (zero wait states). `mem_ready` while `mem_req` is low is ignored.
- Cycles per instruction with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2. Each wait cycle adds 1.
- `illegal_op` is exactly one cycle wide and coincides with the DECODE state.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - Adds `cycle_cnt` (out, `ADDR_W`): increments every cycle out of reset.
  - Adds `instr_cnt` (out, `ADDR_W`): increments on each transition into FETCH from a non-FETCH state, excluding illegal instructions.
  - Both counters are cleared by `rst` and wrap modulo 2^`ADDR_W`.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package `mips_pkg` holds:
  - The state enum.
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants.
  - ALU control codes ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, shared with the ALU.
- Sub-module `mc_alu_decoder` is combinational: funct[5:0] → alu_ctrl[2:0] plus an illegal flag. It is instantiated once, and its output is used in EXEC.

## Test plan
- Reset then lw (opcode 100011), `mem_ready` tied high → states 0,1,2,3,4,0; `reg_write` and `mem_to_reg` are 1 in cycle 5 only.
- R-type slt (funct 101010), `mem_ready` tied high → `alu_ctrl`=111 in EXEC; `reg_dst`=1 and `reg_write`=1 in ALUWB; 4 cycles total.
- beq with `zero`=1 → `pc_en`=1 in BRANCH; with `zero`=0 → `pc_en`=0; both return to FETCH after 3 cycles.
- sw with `mem_ready` low for 3 cycles in MEMWR → `mem_req`=1 and `mem_we`=1 held for 4 cycles, then FETCH.
- Opcode 111111, then R-type funct 000111 → `illegal_op` pulses for 1 cycle each, with no `reg_write` and no `mem_we`.
- Assert `rst` during MEMRD wait → `mem_req` drops in the same cycle, `state_o`=0; the first request after release has `iord`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Definitions shared by the multicycle MIPS control unit and the ALU:
// FSM states, opcode and funct codes, and ALU control codes.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU control code and flags
// functs the datapath cannot execute.
module mc_alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       illegal
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      illegal  = 1'b0;
      case (funct)
         FN_ADD:  alu_ctrl = ALU_ADD;
         FN_SUB:  alu_ctrl = ALU_SUB;
         FN_AND:  alu_ctrl = ALU_AND;
         FN_OR:   alu_ctrl = ALU_OR;
         FN_SLT:  alu_ctrl = ALU_SLT;
         default: illegal  = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM with a variable-latency memory handshake.
// Define MC_CTRL_PERF_EN to add the cycle_cnt / instr_cnt performance counters.
module mc_control
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       illegal_op,
   output logic [3:0] state_o
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [ADDR_W-1:0] cycle_cnt,
   output logic [ADDR_W-1:0] instr_cnt
`endif
);

   state_t     state_reg, state_next;
   logic [2:0] fn_alu_ctrl;
   logic       fn_illegal;
   logic       op_illegal;
   logic       pc_write, pc_write_cond;

   mc_alu_decoder u_alu_decoder (
      .funct    (funct),
      .alu_ctrl (fn_alu_ctrl),
      .illegal  (fn_illegal)
   );

   always_comb begin
      case (opcode)
         OP_RTYPE: op_illegal = fn_illegal;
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_illegal = 1'b0;
         default:  op_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_FETCH;
      else     state_reg <= state_next;
   end

   // Outputs are held at zero during reset so memory sees the request drop at once.
   always_comb begin
      state_next    = state_reg;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_ctrl      = 3'b000;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
      state_o       = 4'd0;
      if (!rst) begin
         state_o = state_reg;
         case (state_reg)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'b01;
               alu_ctrl  = ALU_ADD;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
               alu_src_b  = 2'b11;
               alu_ctrl   = ALU_ADD;
               illegal_op = op_illegal;
               if (op_illegal) state_next = S_FETCH;
               else begin
                  case (opcode)
                     OP_RTYPE:     state_next = S_EXEC;
                     OP_LW, OP_SW: state_next = S_MEMADR;
                     OP_BEQ:       state_next = S_BRANCH;
                     OP_ADDI:      state_next = S_ADDIEX;
                     default:      state_next = S_JUMP;
                  endcase
               end
            end
            S_MEMADR, S_ADDIEX: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               alu_ctrl   = ALU_ADD;
               if (state_reg == S_ADDIEX)  state_next = S_ADDIWB;
               else if (opcode == OP_LW)   state_next = S_MEMRD;
               else                        state_next = S_MEMWR;
            end
            S_MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               state_next = S_FETCH;
            end
            S_MEMWR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
               if (mem_ready) state_next = S_FETCH;
            end
            S_EXEC: begin
               alu_src_a  = 1'b1;
               alu_ctrl   = fn_alu_ctrl;
               state_next = S_ALUWB;
            end
            S_ALUWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               state_next = S_FETCH;
            end
            S_ADDIWB: begin
               reg_write  = 1'b1;
               state_next = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_ctrl      = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_src        = 2'b01;
               state_next    = S_FETCH;
            end
            S_JUMP: begin
               pc_write   = 1'b1;
               pc_src     = 2'b10;
               state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
         endcase
      end
      pc_en = pc_write | (pc_write_cond & zero);
   end

`ifdef MC_CTRL_PERF_EN
   // DECODE->FETCH is only taken by illegal instructions, so it is not retired.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + ADDR_W'(1);
         if (state_reg != S_FETCH && state_reg != S_DECODE && state_next == S_FETCH)
            instr_cnt <= instr_cnt + ADDR_W'(1);
      end
   end
`endif

endmodule
